// File: rtl/imm_pkg.sv
// Shared types and constants for the pipelined immediate generator.
// Format-select encoding, occupancy states and the select width.
package imm_pkg;

    localparam int IMMSRC_W = 3;

    typedef enum logic [IMMSRC_W-1:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100,
        IMM_Z = 3'b101
    } immsrc_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b01,
        OCC_TWO   = 2'b10
    } occ_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extract/extend for RV32I/RV64I formats plus CSR zimm.
// Undefined selects return zero with err set.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [24:0]         instr_31_7,
    input  logic [IMMSRC_W-1:0] immsrc,
    output logic [XLEN-1:0]     immext,
    output logic                err
);

    logic        sign;
    logic [31:0] imm32;

    // Indices below are instruction bit positions minus 7.
    always_comb begin
        sign  = instr_31_7[24];
        imm32 = '0;
        err   = 1'b0;
        case (immsrc_e'(immsrc))
            IMM_I: imm32 = {{20{sign}}, instr_31_7[24:13]};
            IMM_S: imm32 = {{20{sign}}, instr_31_7[24:18], instr_31_7[4:0]};
            IMM_B: imm32 = {{19{sign}}, instr_31_7[24], instr_31_7[0],
                            instr_31_7[23:18], instr_31_7[4:1], 1'b0};
            IMM_J: imm32 = {{11{sign}}, instr_31_7[24], instr_31_7[12:5],
                            instr_31_7[13], instr_31_7[23:14], 1'b0};
            IMM_U: imm32 = {instr_31_7[24:5], 12'b0};
            IMM_Z: imm32 = {27'b0, instr_31_7[12:8]};
            default: err = 1'b1;
        endcase
    end

    // Z has bit 31 clear, so sign-extending every format is correct for RV64.
    if (XLEN == 64) begin : g_ext64
        assign immext = {{32{imm32[31]}}, imm32};
    end else begin : g_ext32
        assign immext = imm32;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with valid/ready handshake and a 2-entry skid buffer.
// Decode happens on the input side; main register drives the outputs directly.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [24:0]         in_instr_31_7,
    input  logic [IMMSRC_W-1:0] in_immsrc,
    input  logic [TAGW-1:0]     in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_immext,
    output logic [TAGW-1:0]     out_tag,
    output logic                out_err
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (TAGW < 1) begin : g_bad_tagw
        $error("imm_gen_pipe: TAGW must be at least 1");
    end

    typedef struct packed {
        logic [XLEN-1:0] immext;
        logic [TAGW-1:0] tag;
        logic            err;
    } imm_entry_t;

    logic [XLEN-1:0] dec_immext;
    logic            dec_err;
    imm_entry_t      dec_entry;

    occ_e       state_q, state_d;
    imm_entry_t main_q, main_d;
    imm_entry_t skid_q, skid_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic       push, pop;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_31_7 (in_instr_31_7),
        .immsrc     (in_immsrc),
        .immext     (dec_immext),
        .err        (dec_err)
    );

    assign dec_entry = '{immext: dec_immext, tag: in_tag, err: dec_err};

    // Handshakes use only registered flags, so out_ready never reaches in_ready.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        push    = in_valid && in_ready_q;
        pop     = out_valid_q && out_ready;
        case (state_q)
            OCC_EMPTY: begin
                if (push) begin
                    state_d = OCC_ONE;
                    main_d  = dec_entry;
                end
            end
            OCC_ONE: begin
                if (push && !pop) begin
                    state_d = OCC_TWO;
                    skid_d  = dec_entry;
                end else if (push && pop) begin
                    main_d  = dec_entry;
                end else if (pop) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (pop) begin
                    state_d = OCC_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
        in_ready_d  = (state_d != OCC_TWO);
        out_valid_d = (state_d != OCC_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= OCC_EMPTY;
            main_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Skid contents only matter while occupied, so no reset is needed.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_immext = main_q.immext;
    assign out_tag    = main_q.tag;
    assign out_err    = main_q.err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are
// compared against a queue-based reference built from the format rules.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [24:0] in_instr_31_7;
    logic [2:0]  in_immsrc;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        ir32, ov32, err32, ir64, ov64, err64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [4:0]  tag32, tag64;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [24:0] f;
        logic [2:0]  src;
        logic [4:0]  tag;
    } entry_t;

    entry_t q[$];
    bit     was_reset;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAGW(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
        .in_instr_31_7(in_instr_31_7), .in_immsrc(in_immsrc), .in_tag(in_tag),
        .out_valid(ov32), .out_ready(out_ready), .out_immext(imm32),
        .out_tag(tag32), .out_err(err32)
    );

    imm_gen_pipe #(.XLEN(64), .TAGW(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64),
        .in_instr_31_7(in_instr_31_7), .in_immsrc(in_immsrc), .in_tag(in_tag),
        .out_valid(ov64), .out_ready(out_ready), .out_immext(imm64),
        .out_tag(tag64), .out_err(err64)
    );

    // Returns {err, 64-bit immediate}; XLEN=32 expectation is the low half.
    function automatic logic [64:0] ref_imm(logic [24:0] f, logic [2:0] src);
        logic [31:0]        instr;
        logic signed [11:0] v12;
        logic signed [12:0] v13;
        logic signed [20:0] v21;
        logic signed [31:0] v32;
        longint             v;
        instr = {f, 7'b0};
        v = 0;
        case (src)
            3'd0: begin v12 = instr[31:20]; v = v12; end
            3'd1: begin v12 = {instr[31:25], instr[11:7]}; v = v12; end
            3'd2: begin v13 = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}; v = v13; end
            3'd3: begin v21 = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}; v = v21; end
            3'd4: begin v32 = {instr[31:12], 12'b0}; v = v32; end
            3'd5: v = longint'(instr[19:15]);
            default: return {1'b1, 64'd0};
        endcase
        return {1'b0, v};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        logic [64:0] r;
        chk("ov32", {63'd0, ov32}, {63'd0, q.size() > 0});
        chk("ov64", {63'd0, ov64}, {63'd0, q.size() > 0});
        chk("ir32", {63'd0, ir32}, {63'd0, q.size() < 2});
        chk("ir64", {63'd0, ir64}, {63'd0, q.size() < 2});
        if (was_reset) begin
            chk("rst_imm32", {32'd0, imm32}, 64'd0);
            chk("rst_imm64", imm64, 64'd0);
            chk("rst_tag", {54'd0, tag32, tag64}, 64'd0);
            chk("rst_err", {62'd0, err32, err64}, 64'd0);
        end else if (q.size() > 0) begin
            r = ref_imm(q[0].f, q[0].src);
            chk("imm32", {32'd0, imm32}, {32'd0, r[31:0]});
            chk("imm64", imm64, r[63:0]);
            chk("tag32", {59'd0, tag32}, {59'd0, q[0].tag});
            chk("tag64", {59'd0, tag64}, {59'd0, q[0].tag});
            chk("err32", {63'd0, err32}, {63'd0, r[64]});
            chk("err64", {63'd0, err64}, {63'd0, r[64]});
        end
    endtask

    // One clock: predict handshakes from the model occupancy, advance, check.
    task automatic cycle();
        bit     push, pop;
        entry_t e;
        push = rst_n && in_valid && (q.size() < 2);
        pop  = rst_n && (q.size() > 0) && out_ready;
        e = '{f: in_instr_31_7, src: in_immsrc, tag: in_tag};
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            was_reset = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
            was_reset = 1'b0;
        end
        #1;
        check_outputs();
    endtask

    task automatic drive(logic v, logic [31:0] instr, logic [2:0] src, logic [4:0] tag);
        in_valid      = v;
        in_instr_31_7 = instr[31:7];
        in_immsrc     = src;
        in_tag        = tag;
    endtask

    task automatic push_one(logic [31:0] instr, logic [2:0] src, logic [4:0] tag);
        drive(1'b1, instr, src, tag);
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        was_reset = 1'b0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'hFFFF_FFFF, 3'd0, 5'd31);
        cycle();
        cycle();
        rst_n = 1'b1;
        in_valid = 1'b0;

        // Spec vectors, each followed by a constant check.
        push_one(32'hFFF00093, 3'd0, 5'd3);
        chk("i_const", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFF);
        chk("i_tag_const", {59'd0, tag32}, 64'd3);
        push_one(32'hFE000EE3, 3'd2, 5'd4);
        chk("b_const", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFC);
        push_one(32'h0080006F, 3'd3, 5'd5);
        chk("j_const", {32'd0, imm32}, 64'h0000_0000_0000_0008);
        push_one(32'h800000B7, 3'd4, 5'd6);
        chk("u64_const", imm64, 64'hFFFF_FFFF_8000_0000);
        push_one(32'h000F8073, 3'd5, 5'd7);
        chk("z64_const", imm64, 64'h0000_0000_0000_001F);
        push_one(32'h12345678, 3'd7, 5'd8);
        chk("err_const", {62'd0, err32, err64}, 64'd3);
        chk("err_imm_const", imm64, 64'd0);
        push_one(32'hFFFFFFFF, 3'd1, 5'd9);
        cycle();

        // Backpressure: tags 1,2,3 pushed with out_ready low.
        out_ready = 1'b0;
        drive(1'b1, 32'h00100013, 3'd0, 5'd1);
        cycle();
        drive(1'b1, 32'h00200013, 3'd0, 5'd2);
        cycle();
        chk("bp_in_ready_low", {63'd0, ir32}, 64'd0);
        drive(1'b1, 32'h00300013, 3'd0, 5'd3);
        cycle();
        cycle();
        chk("bp_hold_tag", {59'd0, tag32}, 64'd1);
        out_ready = 1'b1;
        cycle();
        chk("bp_order2", {59'd0, tag32}, 64'd2);
        cycle();
        chk("bp_order3", {59'd0, tag32}, 64'd3);
        in_valid = 1'b0;
        cycle();

        // Streaming: back-to-back random entries with out_ready high.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, $urandom, 3'($urandom_range(0, 7)), 5'($urandom));
            cycle();
            chk("stream_in_ready", {63'd0, ir32 & ir64}, 64'd1);
        end
        in_valid = 1'b0;
        cycle();

        // Reset while TWO entries are held.
        out_ready = 1'b0;
        push_one(32'hFFF00093, 3'd0, 5'd11);
        push_one(32'h800000B7, 3'd4, 5'd12);
        chk("two_in_ready", {63'd0, ir64}, 64'd0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        out_ready = 1'b1;
        push_one(32'h0080006F, 3'd3, 5'd13);
        chk("post_rst_tag", {59'd0, tag64}, 64'd13);
        cycle();
        chk("post_rst_empty", {63'd0, ov64}, 64'd0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), $urandom, 3'($urandom_range(0, 7)), 5'($urandom));
            out_ready = 1'($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator sitting between the decode stage and the ID/EX register. It extracts and extends the immediate from instruction bits [31:7] for all RV32I/RV64I formats plus the CSR zero-extended `zimm`. It carries a sideband tag and decouples producer and consumer with a valid/ready handshake and a 2-entry skid buffer. It flags undefined format selects instead of silently producing zero.

## Interface
Parameters:
- `XLEN`, 32: output width; 32 or 64 only; any other value is an elaboration error.
- `TAGW`, 5: width of the sideband tag carried alongside each immediate (e.g. rd index); minimum 1.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: upstream offers an instruction.
- `in_ready` out 1: block can accept; registered.
- `in_instr_31_7` in 25: instruction bits [31:7].
- `in_immsrc` in 3: format select (encoding below).
- `in_tag` in TAGW: sideband, passed through unchanged.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts.
- `out_immext` out XLEN: extended immediate.
- `out_tag` out TAGW: tag of the result.
- `out_err` out 1: `in_immsrc` was undefined; `out_immext` is 0.

## Operation
- Format encoding of `in_immsrc`:
  - 000: I, sign-extended.
  - 001: S, sign-extended.
  - 010: B, sign-extended, bit0 = 0.
  - 011: J, sign-extended, bit0 = 0.
  - 100: U, {instr[31:12], 12'b0}; sign-extended from bit 31 when XLEN=64.
  - 101: Z, instr[19:15] zero-extended.
  - 110, 111: undefined; immediate 0, `out_err`=1.
- Sign bit is always instr[31]; all extension is to XLEN.
- Transfer in: `in_valid && in_ready` at a clock edge. Transfer out: `out_valid && out_ready`.
- Storage is a main output register plus one skid register. Occupancy states:
  - EMPTY: `out_valid`=0, `in_ready`=1.
  - ONE: main full, `out_valid`=1, `in_ready`=1.
  - TWO: main and skid full, `out_valid`=1, `in_ready`=0.
- Transitions:
  - EMPTY + in → ONE.
  - ONE + in, no out → TWO.
  - ONE + out, no in → EMPTY.
  - ONE + in + out → ONE, with main loaded with the new entry.
  - TWO + out → ONE, with skid moving to main.
  - TWO with no out holds.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- While `out_valid`=1 and `out_ready`=0, `out_immext`, `out_tag` and `out_err` are held stable.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is on the outputs after edge N, when the block was EMPTY, or when it was ONE with a simultaneous out transfer.
- Throughput is 1 per cycle with `out_ready` held high.
- `in_ready` depends only on registered state, with no combinational path from `out_ready`. `out_valid` is likewise registered.
- Reset, on any edge with `rst_n`=0: state EMPTY, `out_valid`=0, `in_ready`=1, `out_immext`=0, `out_tag`=0, `out_err`=0. Handshakes presented in a reset cycle are discarded. Reset mid-operation flushes both entries.
- `in_*` data is ignored when `in_valid`=0. Skid contents are don't-care when not occupied.

## Structure
- Package `imm_pkg`:
  - Enum `immsrc_e` with I, S, B, J, U, Z.
  - Constant `IMMSRC_W` = 3.
  - Packed struct `imm_entry_t` holding immext, tag and err, parametrised via XLEN-sized field in module.
- Sub-module `imm_decode`: purely combinational format decode/extend, with parameter XLEN. `imm_gen_pipe` instantiates it once on the input side and registers its result. The skid/occupancy logic lives in `imm_gen_pipe`.

## Test plan
- I-type, XLEN=32, `in_instr_31_7`=0xFFF00093>>7, immsrc 000, tag 3, `out_ready`=1 → next cycle `out_immext`=0xFFFFFFFF, `out_tag`=3, `out_err`=0.
- B-type 0xFE000EE3 (beq, −4) → 0xFFFFFFFC. J-type 0x0080006F (jal +8) → 0x00000008.
- U-type, XLEN=64: 0x800000B7 → 0xFFFFFFFF80000000. Z-type with rs1 field 11111 → 0x000000000000001F. immsrc 111 → immext 0, `out_err`=1.
- Backpressure: `out_ready`=0 while pushing tags 1,2,3 back-to-back → 1 and 2 accepted, `in_ready`=0 after the second accept, 3 held upstream. Raise `out_ready` → tags exit in order 1,2,3, one per cycle, and output stays stable while stalled.
- Streaming: 16 random instructions with `out_ready`=1 → one result per cycle, matching the `imm_decode` model, with in_ready never low.
- Reset in TWO state: assert `rst_n`=0 for one edge → `out_valid`=0, `in_ready`=1, all outputs 0. The next accepted entry appears alone with no stale data.
